// File: rtl/mult_sched_pkg.sv
`default_nettype none
// ============================================================================
// mult_sched_pkg : shared types and widths for the multiplier scheduler
// Revision: 1.0
// ============================================================================
package mult_sched_pkg;

   localparam int NUM_REQ  = 2;
   localparam int DATA_W   = 8;
   localparam int RESULT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// rr_arbiter_2 : two-way round-robin grant; ptr_i names the last winner
// Revision: 1.0
// ============================================================================
module rr_arbiter_2
   import mult_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic               ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   always_comb begin
      grant_o = '0;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         // On a tie the requester that did not win last time goes first
         2'b11:   grant_o = ptr_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mult_scheduler.sv
`default_nettype none
// ============================================================================
// mult_scheduler : shares one multi-cycle multiplier between two requesters
// Revision: 1.0
// ============================================================================
module mult_scheduler
   import mult_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 40
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_id,
   output logic [RESULT_W-1:0]         rsp_result,
   output logic                        rsp_err,
   output logic                        mul_start,
   output logic [DATA_W-1:0]           mul_a,
   output logic [DATA_W-1:0]           mul_b,
   input  logic [RESULT_W-1:0]         mul_result,
   input  logic                        mul_done,
   output logic                        busy
);

   localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  id_q, id_d;
   logic [DATA_W-1:0]     a_q, a_d;
   logic [DATA_W-1:0]     b_q, b_d;
   logic [RESULT_W-1:0]   res_q, res_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [NUM_REQ-1:0]    w_grant;
   logic                  w_sel;

   rr_arbiter_2 u_arb (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (w_grant)
   );

   assign w_sel = w_grant[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b1;
         id_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      req_ready = '0;

      case (state_q)
         IDLE: begin
            // Gated with rst_n so every output reads zero while reset is held
            req_ready = rst_n ? w_grant : '0;
            if (rst_n && |(req_valid & w_grant)) begin
               ptr_d   = w_sel;
               id_d    = w_sel;
               a_d     = w_sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
               b_d     = w_sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            // Completion takes priority over a simultaneous timeout
            if (mul_done) begin
               res_d   = mul_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign mul_start  = (state_q == ISSUE);
   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != IDLE);

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_ready_idle   : assert property (@(posedge clk) disable iff (!rst_n) busy |-> (req_ready == '0));

endmodule
`default_nettype wire

// File: tb/tb_mult_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mult_scheduler : vector table, directed reset cases and random traffic
// Revision: 1.0
// ============================================================================
module tb_mult_scheduler;

   localparam int TO = 40;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_result;
   logic        mul_done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int mdl_delay = 1;
   int m_cnt;
   logic m_active;

   mult_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: done pulses mdl_delay cycles after the start cycle
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active   <= 1'b0;
         m_cnt      <= 0;
         mul_done   <= 1'b0;
         mul_result <= '0;
      end else begin
         mul_done <= 1'b0;
         if (mul_start) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
         end else if (m_active) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == mdl_delay) begin
               mul_done   <= 1'b1;
               mul_result <= 16'(mul_a) * 16'(mul_b);
               m_active   <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
         chk("req_ready_while_busy", 32'(busy && (req_ready != 2'b00)), 32'd0);
      end
   end

   task automatic do_txn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1, input int d, input int stall,
                         input logic exp_id, input logic [15:0] exp_res, input logic exp_err);
      logic [7:0] ea;
      logic [7:0] eb;
      int lat;
      int n;
      ea  = exp_id ? a1 : a0;
      eb  = exp_id ? b1 : b0;
      lat = (d > TO) ? TO : d;
      mdl_delay = d;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("grant", 32'(req_ready), exp_id ? 32'd2 : 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      chk("issue_start", 32'(mul_start), 32'd1);
      chk("issue_mul_a", 32'(mul_a), 32'(ea));
      chk("issue_mul_b", 32'(mul_b), 32'(eb));
      chk("issue_busy", 32'(busy), 32'd1);
      n = 1;
      while (!rsp_valid && n < lat + 10) begin
         @(negedge clk);
         n++;
         if (!rsp_valid) begin
            chk("wait_start_low", 32'(mul_start), 32'd0);
            chk("wait_mul_a", 32'({mul_a, mul_b}), 32'({ea, eb}));
         end
      end
      chk("rsp_latency", 32'(n), 32'(lat + 2));
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_id", 32'(rsp_id), 32'(exp_id));
         chk("rsp_result", 32'(rsp_result), 32'(exp_res));
         chk("rsp_err", 32'(rsp_err), 32'(exp_err));
         chk("rsp_req_ready", 32'(req_ready), 32'd0);
         chk("rsp_busy", 32'(busy), 32'd1);
         if (s < stall) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
   endtask

   typedef struct packed {
      logic [1:0]  v;
      logic [7:0]  a0;
      logic [7:0]  b0;
      logic [7:0]  a1;
      logic [7:0]  b1;
      logic [10:0] d;
      logic [3:0]  stall;
      logic        id;
      logic [15:0] res;
      logic        err;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       seen;
      logic       rr_last;
      logic [1:0] v;
      logic [7:0] a0, b0, a1, b1;
      logic       eid;
      logic       eerr;
      logic [15:0] eres;
      int         d;

      tbl[0] = '{2'b11, 8'd255, 8'd255, 8'd3,   8'd5,   11'd3,    4'd0, 1'b0, 16'd65025, 1'b0};
      tbl[1] = '{2'b11, 8'd255, 8'd255, 8'd3,   8'd5,   11'd5,    4'd0, 1'b1, 16'd15,    1'b0};
      tbl[2] = '{2'b01, 8'd12,  8'd13,  8'd0,   8'd0,   11'd9,    4'd0, 1'b0, 16'd156,   1'b0};
      tbl[3] = '{2'b10, 8'd0,   8'd0,   8'd200, 8'd100, 11'd2,    4'd5, 1'b1, 16'd20000, 1'b0};
      tbl[4] = '{2'b01, 8'd9,   8'd9,   8'd0,   8'd0,   11'd1000, 4'd1, 1'b0, 16'd0,     1'b1};
      tbl[5] = '{2'b10, 8'd0,   8'd0,   8'd7,   8'd9,   11'd40,   4'd0, 1'b1, 16'd63,    1'b0};
      tbl[6] = '{2'b11, 8'd2,   8'd3,   8'd4,   8'd5,   11'd41,   4'd0, 1'b0, 16'd0,     1'b1};
      tbl[7] = '{2'b11, 8'd6,   8'd7,   8'd17,  8'd19,  11'd1,    4'd2, 1'b1, 16'd323,   1'b0};
      tbl[8] = '{2'b01, 8'd255, 8'd1,   8'd0,   8'd0,   11'd1,    4'd0, 1'b0, 16'd255,   1'b0};

      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_outputs", 32'({rsp_valid, rsp_id, rsp_err, mul_start, req_ready}), 32'd0);
      chk("reset_data", 32'({mul_a, mul_b, rsp_result}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         do_txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, int'(tbl[i].d),
                int'(tbl[i].stall), tbl[i].id, tbl[i].res, tbl[i].err);
      end

      // Reset while waiting on the multiplier
      mdl_delay = 1000;
      req_valid = 2'b01; req_a = 16'd50; req_b = 16'd60;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      chk("rstwait_start", 32'(mul_start), 32'd1);
      repeat (5) @(negedge clk);
      chk("rstwait_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstwait_busy", 32'(busy), 32'd0);
      chk("rstwait_outputs", 32'({rsp_valid, rsp_id, rsp_err, mul_start, req_ready}), 32'd0);
      chk("rstwait_data", 32'({mul_a, mul_b, rsp_result}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (rsp_valid || busy) seen = 1'b1;
      end
      chk("no_rsp_after_reset", 32'(seen), 32'd0);

      // Reset during the start pulse
      mdl_delay = 3;
      req_valid = 2'b10; req_a = 16'h0900; req_b = 16'h0900;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      chk("rstissue_start", 32'(mul_start), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstissue_start_drop", 32'(mul_start), 32'd0);
      chk("rstissue_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(2'b11, 8'd21, 8'd2, 8'd8, 8'd8, 4, 1, 1'b0, 16'd42, 1'b0);

      // Random traffic against a transaction-level reference
      rr_last = 1'b0;
      for (int k = 0; k < 40; k++) begin
         v  = 2'($urandom_range(1, 3));
         a0 = 8'($urandom); b0 = 8'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom);
         d  = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, 44));
         if (v == 2'b11) eid = ~rr_last;
         else            eid = (v == 2'b10);
         eerr = (d > TO);
         eres = eerr ? 16'd0 : (eid ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0));
         rr_last = eid;
         do_txn(v, a0, b0, a1, b1, d, int'($urandom_range(0, 3)), eid, eres, eerr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 40, maximum cycles spent in WAIT before a transaction is aborted.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 req_a  input  16  packed operands A; [7:0] requester 0, [15:8] requester 1.
REQ-007 req_b  input  16  packed operands B; same packing as req_a.
REQ-008 rsp_valid  output  1  response valid.
REQ-009 rsp_ready  input  1  response consumer ready.
REQ-010 rsp_id  output  1  index of the requester owning the response.
REQ-011 rsp_result  output  16  product A*B.
REQ-012 rsp_err  output  1  transaction aborted by timeout.
REQ-013 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-014 mul_a, mul_b  output  8 each  operands to the multiplier.
REQ-015 mul_result  input  16  multiplier product.
REQ-016 mul_done  input  1  multiplier completion flag.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; no other states.
REQ-019 In IDLE, req_ready SHALL assert combinationally for exactly one requester with req_valid=1, selected round-robin; transfer occurs when req_valid[i]&req_ready[i] on a rising edge.
REQ-020 Round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer; pointer updates only on a transfer.
REQ-021 On transfer: latch operands and requester index, go to ISSUE.
REQ-022 ISSUE: mul_start=1 for exactly one cycle; go to WAIT; clear timeout counter.
REQ-023 mul_a/mul_b SHALL equal the latched operands from ISSUE through end of WAIT and hold stable.
REQ-024 mul_done SHALL be sampled only in WAIT; ignored in all other states.
REQ-025 WAIT: counter increments each cycle; mul_done=1 captures mul_result, rsp_err=0, go to RESP.
REQ-026 WAIT: counter reaching TIMEOUT_CYCLES-1 without mul_done -> rsp_result=0, rsp_err=1, go to RESP.
REQ-027 mul_done and timeout in the same cycle: done wins, rsp_err=0.
REQ-028 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_err held stable until rsp_valid&rsp_ready; then go to IDLE.
REQ-029 req_ready SHALL be 0 in ISSUE, WAIT, RESP; no new request accepted before response completes.
REQ-030 Latency: transfer at edge N, mul_start high cycle N+1; mul_done first seen cycle N+1+k (k>=1) -> rsp_valid high from cycle N+2+k.
REQ-031 rsp_result is full 16-bit unsigned product; 255*255=65025 without truncation.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, all outputs 0, latches 0, counter 0, round-robin pointer to 1 (requester 0 wins first tie).
REQ-033 Reset mid-transaction abandons it; no response issued after release; mul_start drops immediately.

Structure
REQ-034 Package mult_sched_pkg holds state_t enum, NUM_REQ=2, DATA_W=8, RESULT_W=16.
REQ-035 Sub-module rr_arbiter_2 (inputs valid[1:0], pointer; output one-hot grant) SHALL implement the grant logic.

Verification
REQ-036 Req0 A=12 B=13, model done 9 cycles after start returning 156 -> rsp_valid, id=0, result=156, err=0, timing per REQ-030.
REQ-037 Both valid after reset, (255,255) and (3,5) -> id0 result 65025 first, then id1 result 15; req_ready never two-hot.
REQ-038 rsp_ready low 5 cycles in RESP -> response fields stable, req_ready=00, busy=1.
REQ-039 Model never asserts done -> after TIMEOUT_CYCLES WAIT cycles rsp_err=1, result=0.
REQ-040 mul_done asserted in the timeout cycle -> err=0, result captured.
REQ-041 rst_n low during WAIT -> outputs 0 asynchronously; no response after release; next request completes normally.
